// File: rtl/bictr_sweep_ctrl.sv
// Triangle-sweep master for the up/down counter with dynamic count-to.
// Runs lo->hi->lo sweeps with endpoint dwell, stopping on tercnt only.
module bictr_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [3:0]       cmd_cycles,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       sweep_cnt,
  output logic             ctr_load,
  output logic [WIDTH-1:0] ctr_data,
  output logic             ctr_cen,
  output logic             ctr_up_dn,
  output logic [WIDTH-1:0] ctr_count_to,
  input  logic [WIDTH-1:0] ctr_count,
  input  logic             ctr_tercnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DWELL_HI,
    S_DOWN,
    S_DWELL_LO,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [3:0]       cycles_q;
  logic [3:0]       sweep_q;
  logic [3:0]       dwell_q;
  logic             up_q;
  logic             err_q;
  logic             busy_q;
  logic             accept;
  logic             reject;
  logic             sweep_inc;
  logic             in_dwell;
  logic             dwell_end;
  logic             cmd_ok;
  logic             unused_dbg;

  // Count value is debug visibility only; tercnt alone steers the FSM.
  assign unused_dbg = ^ctr_count;

  assign cmd_ok    = (cmd_lo < cmd_hi) && (cmd_cycles != 4'd0);
  assign in_dwell  = (state_q == S_DWELL_HI) ||
                     (state_q == S_DWELL_LO);
  assign dwell_end = dwell_q == 4'(DWELL - 1);

  always_comb begin
    state_d      = state_q;
    ctr_load     = 1'b0;
    ctr_data     = '0;
    ctr_cen      = 1'b0;
    ctr_count_to = '0;
    sweep_inc    = 1'b0;
    accept       = 1'b0;
    reject       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cmd_ok) begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        ctr_load     = 1'b1;
        ctr_data     = lo_q;
        ctr_count_to = hi_q;
        state_d      = S_UP;
      end
      S_UP: begin
        ctr_count_to = hi_q;
        ctr_cen      = !ctr_tercnt;
        if (ctr_tercnt) state_d = S_DWELL_HI;
      end
      S_DWELL_HI: begin
        ctr_count_to = lo_q;
        if (dwell_end) state_d = S_DOWN;
      end
      S_DOWN: begin
        ctr_count_to = lo_q;
        ctr_cen      = !ctr_tercnt;
        if (ctr_tercnt) begin
          sweep_inc = 1'b1;
          if (sweep_q + 4'd1 == cycles_q)
            state_d = S_DONE;
          else
            state_d = S_DWELL_LO;
        end
      end
      S_DWELL_LO: begin
        ctr_count_to = hi_q;
        if (dwell_end) state_d = S_UP;
      end
      S_DONE: begin
        ctr_count_to = lo_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort must stop stepping in the same cycle it is seen.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      ctr_cen   = 1'b0;
      sweep_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cycles_q <= '0;
      sweep_q  <= '0;
      dwell_q  <= '0;
      up_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != S_IDLE;
      err_q   <= reject;
      if (accept) begin
        lo_q     <= cmd_lo;
        hi_q     <= cmd_hi;
        cycles_q <= cmd_cycles;
        sweep_q  <= '0;
      end else if (sweep_inc) begin
        sweep_q  <= sweep_q + 4'd1;
      end
      if (in_dwell && !dwell_end)
        dwell_q <= dwell_q + 4'd1;
      else
        dwell_q <= '0;
      if (state_d == S_UP)
        up_q <= 1'b1;
      else if (state_d == S_DOWN)
        up_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = state_q == S_DONE;
  assign err       = err_q;
  assign sweep_cnt = sweep_q;
  assign ctr_up_dn = up_q;

endmodule

// File: doc/bictr_sweep_ctrl.md
Name: bictr_sweep_ctrl

Overview:
- Master-side controller for the team's up/down binary counter with dynamic count-to flag.
- Drives the counter's control inputs: load, data, cen, up_dn, count_to.
- Monitors the counter's count and tercnt outputs to run a programmed number of triangle sweeps (lo→hi→lo), holding at each endpoint for a fixed dwell time.
- Sits between a command source (start/abort handshake) and one counter instance.

Parameters:
- WIDTH, 4, counter data width; all value ports are this width.
- DWELL, 2, cycles held at each endpoint with cen low; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- start  input  1  command strobe, sampled in IDLE only
- abort  input  1  synchronous abort, any state
- cmd_lo  input  WIDTH  sweep low endpoint
- cmd_hi  input  WIDTH  sweep high endpoint
- cmd_cycles  input  4  number of full sweeps (lo→hi→lo)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on normal completion
- err  output  1  one-cycle pulse on rejected command
- sweep_cnt  output  4  completed sweeps of current command
- ctr_load  output  1  to counter load
- ctr_data  output  WIDTH  to counter data
- ctr_cen  output  1  to counter cen
- ctr_up_dn  output  1  to counter up_dn (1 = up)
- ctr_count_to  output  WIDTH  to counter count_to
- ctr_count  input  WIDTH  from counter count
- ctr_tercnt  input  1  from counter tercnt (combinational compare)

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; all outputs 0; latched lo/hi/cycles cleared. Reset mid-operation behaves identically; no done is produced.
- States: IDLE, LOAD, UP, DWELL_HI, DOWN, DWELL_LO, DONE.
- IDLE:
  - start=1 with cmd_lo<cmd_hi (unsigned, strict) and cmd_cycles!=0 → latch the command, sweep_cnt=0, go to LOAD.
  - start=1 otherwise → err=1 for the next cycle, stay in IDLE.
- LOAD (1 cycle): ctr_load=1, ctr_data=lo, ctr_cen=0 → UP.
- UP: ctr_up_dn=1, ctr_count_to=hi, ctr_cen = !ctr_tercnt (Mealy). ctr_tercnt=1 → DWELL_HI. If the count already equals hi on entry, zero steps are taken.
- DWELL_HI:
  - ctr_cen=0, ctr_count_to=lo.
  - Dwell counter runs DWELL cycles, then → DOWN.
  - tercnt is ignored in this state.
- DOWN: ctr_up_dn=0, ctr_count_to=lo, ctr_cen = !ctr_tercnt.
  - On ctr_tercnt=1, sweep_cnt increments.
  - If the new sweep_cnt == cycles → DONE; else → DWELL_LO.
- DWELL_LO: same as DWELL_HI but holds at lo, then → UP.
- DONE (1 cycle): done=1, cen=0 → IDLE.
- busy is registered from state: high in every non-IDLE state, including DONE.
- ctr_up_dn holds its last value in dwell states.
- ctr_data=0 outside LOAD; ctr_count_to=0 in IDLE.
- abort=1 in any non-IDLE state → IDLE next cycle. ctr_cen is forced to 0 combinationally in the abort cycle. No done; sweep_cnt is retained until the next accepted start.
- Priority: reset > abort > state logic. start is ignored while busy.
- Wrap-around cannot occur: lo<hi is enforced and cen drops on tercnt before the counter steps past an endpoint.
- ctr_count is observed for debug only and does not affect control. ctr_tercnt is the sole stop condition.

Test Plan:
- lo=2, hi=5, cycles=1, DWELL=2; start at cycle 0:
  - ctr_load=1 at cycle 1.
  - cen=1 at cycles 2–4 (count 2→5); cen=0 at cycle 5.
  - Dwell at cycles 6–7; cen=1 at cycles 8–10 (count 5→2); tercnt at cycle 11.
  - done=1 at cycle 12; busy high cycles 1–12; sweep_cnt=1.
- lo=0, hi=15, cycles=3: count spans 0..15 three times with no wrap past 15 or below 0; sweep_cnt 1,2,3; exactly one done pulse.
- Invalid commands (lo=7, hi=7), (lo=9, hi=3), (cycles=0): err pulses one cycle, busy stays 0, no ctr_load.
- abort asserted during UP at count=4: ctr_cen=0 the same cycle, IDLE next cycle, no done, count frozen at 4.
- reset driven low during DWELL_LO: all outputs 0 the cycle after the edge. A new start after release runs normally.
- start held high throughout a command: no re-latch while busy. After DONE, a new command starts from IDLE the next cycle.
